gray_fifo_pointer: RTL and testbench
====================================

Name: gray_fifo_pointer

Overview:
- Parametrised successor to the plain Gray counter: one side (write or read) of an asynchronous-FIFO pointer pair.
- Holds a registered binary/Gray pointer one bit wider than the address and synchronises the peer domain's Gray pointer through a configurable flop chain.
- Computes full (write side) or empty (read side) and gates the advance handshake with it.
- Two instances, one per clock domain, form the pointer logic of a dual-clock FIFO.

Parameters:
ADDR_WIDTH, 4, FIFO address bits; depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits; legal range >= 2.
SYNC_STAGES, 2, flops in the peer-pointer synchroniser; legal range >= 2.
SIDE, 0, 0 = write side (status is full), 1 = read side (status is empty).

Ports:
CLK  input  1  sole clock; all state is on its rising edge
RST  input  1  synchronous reset, active-high
advance__ENA  input  1  request to move the pointer by one entry
advance__RDY  output  1  advance accepted this cycle; write side = !full, read side = !empty
clear__ENA  input  1  synchronous local clear of the pointer to zero
peerGray  input  ADDR_WIDTH+1  peer-domain Gray pointer; asynchronous to CLK
ptrGray  output  ADDR_WIDTH+1  registered Gray pointer, for export to the peer domain
ptrBin  output  ADDR_WIDTH+1  registered binary pointer
addr  output  ADDR_WIDTH  RAM address, equal to ptrBin[ADDR_WIDTH-1:0]

Behaviour:
- Interface: one clock, CLK; reset RST is synchronous and active-high.
- Reset (RST=1 at an edge) clears to 0: ptrBin, ptrGray and every synchroniser stage.
  - After reset, write side: advance__RDY=1. Read side: advance__RDY=0.
- Reset mid-operation: RST overrides all other inputs in the same cycle.
- Pointer state: ptrBin and ptrGray are both flops. ptrGray is always gray(ptrBin) = ptrBin ^ (ptrBin>>1).
  - No combinational path from any input to ptrGray.
- Advance: on an edge with advance__ENA && advance__RDY, ptrBin <= ptrBin+1 mod 2**(ADDR_WIDTH+1). ptrGray updates on the same edge. Latency 1 cycle.
  - advance__ENA while advance__RDY=0 is ignored; no state change.
- Wrap-around: at ptrBin = all ones, the pointer goes to 0 and ptrGray goes to 0.
  - Top-bit toggling on wrap gives the full/empty disambiguation.
- Clear: clear__ENA=1 sets ptrBin=ptrGray=0 on the next edge.
  - Takes priority over a simultaneous advance; the advance is dropped.
  - The synchroniser is not cleared.
- Synchroniser: peerGray feeds stage 0; stage k <= stage k-1 each cycle. peerSync = last stage.
  - A peer change is visible in status exactly SYNC_STAGES edges later.
- Status is combinational from registered ptrGray and peerSync only. W = ADDR_WIDTH.
  - Write side: full = (ptrGray == {~peerSync[W:W-1], peerSync[W-2:0]}).
  - Read side: empty = (ptrGray == peerSync).
- advance__RDY is valid in the cycle after any pointer update, so back-to-back advances are accepted until the boundary.
  - Write side: the Nth consecutive advance with a static peer sets full in the following cycle, N = 2**W.
  - Read side: the advance that reaches peerSync sets empty in the following cycle.
- No multi-bit change on ptrGray: exactly one bit toggles per accepted advance. Clear and reset are exempt.

Optional Feature:
GRAY_PTR_LEVEL_EN
- Defined: adds output level [ADDR_WIDTH:0], registered and updated every cycle from current state.
  - peerBin = Gray-to-binary(peerSync).
  - Write side: level = ptrBin - peerBin, i.e. occupancy.
  - Read side: level = peerBin - ptrBin, i.e. available entries.
  - Both are mod 2**(ADDR_WIDTH+1). level reflects state 1 cycle late. Reset value 0.
- Not defined: port and logic absent. All other behaviour is identical.

Test Plan:
1. Write side, W=2, SYNC_STAGES=2, peerGray=0, RST one cycle then four advances. Required: ptrGray steps 001, 011, 010, 110; advance__RDY=0 after the 4th. A 5th advance leaves ptrBin=100.
2. Continue from 1, set peerGray=001. Required: advance__RDY stays 0 for the first 2 edges and is 1 after the 2nd. One advance gives ptrBin=101, ptrGray=111, then full again.
3. Read side, W=2. Required: after reset advance__RDY=0. Set peerGray=010 (bin 3): RDY=1 after 2 edges. Three advances give ptrBin=011, then RDY=0. ENA held high causes no further change.
4. Wrap: write side, peerGray driven to track ptrGray with 2-cycle lag. Apply 9 accepted advances. Required: ptrBin sequence 0..7,0,1. ptrGray 100 -> 000 on wrap, with single-bit change checked on every step.
5. Clear priority and reset mid-op: ptrBin=101, drive clear__ENA=1 and advance__ENA=1 together. Required: ptrBin=000 next cycle. Then advance twice and assert RST with advance__ENA=1. Required: ptrBin=ptrGray=0 and synchroniser = 0.
6. GRAY_PTR_LEVEL_EN defined, write side, W=2, peer=0. Three advances. Required: level reads 1, 2, 3 one cycle after each. Then set peerGray=011 (bin 2). Required: level = 1 three edges later (2 sync + 1 register).

Source files
------------

// File: rtl/gray_fifo_pointer_if.sv
// gray_fifo_pointer_if
//   Bundles the pointer handshake and pointer/status signals for one side
//   of a dual-clock FIFO pointer pair.
//   slave  : used by gray_fifo_pointer (drives RDY, pointers, addr, level)
//   master : used by the logic that requests advances/clears and supplies
//            the peer-domain Gray pointer
//   Optional: GRAY_PTR_LEVEL_EN adds the registered level signal.
interface gray_fifo_pointer_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  advance__ENA;
  logic                  advance__RDY;
  logic                  clear__ENA;
  logic [ADDR_WIDTH:0]   peerGray;
  logic [ADDR_WIDTH:0]   ptrGray;
  logic [ADDR_WIDTH:0]   ptrBin;
  logic [ADDR_WIDTH-1:0] addr;
`ifdef GRAY_PTR_LEVEL_EN
  logic [ADDR_WIDTH:0]   level;

  modport slave (
    input  advance__ENA, clear__ENA, peerGray,
    output advance__RDY, ptrGray, ptrBin, addr, level
  );
  modport master (
    output advance__ENA, clear__ENA, peerGray,
    input  advance__RDY, ptrGray, ptrBin, addr, level
  );
`else
  modport slave (
    input  advance__ENA, clear__ENA, peerGray,
    output advance__RDY, ptrGray, ptrBin, addr
  );
  modport master (
    output advance__ENA, clear__ENA, peerGray,
    input  advance__RDY, ptrGray, ptrBin, addr
  );
`endif
endinterface

// File: rtl/gray_fifo_pointer.sv
// gray_fifo_pointer
//   One side (write or read) of an asynchronous-FIFO pointer pair.
//   Holds a registered binary + Gray pointer (ADDR_WIDTH+1 bits), brings the
//   peer domain's Gray pointer in through a SYNC_STAGES flop chain and
//   derives full (SIDE=0) or empty (SIDE=1), which gates the advance.
// Ports:
//   CLK  : sole clock, rising edge
//   RST  : synchronous reset, active-high, clears pointers and synchroniser
//   bus  : gray_fifo_pointer_if.slave
//          advance__ENA/advance__RDY : advance handshake
//          clear__ENA               : local pointer clear (sync not cleared)
//          peerGray                 : peer Gray pointer (asynchronous)
//          ptrGray/ptrBin/addr      : registered pointer outputs
//          level                    : only with GRAY_PTR_LEVEL_EN
// Optional feature macro: GRAY_PTR_LEVEL_EN
//   Adds a registered level output: occupancy on the write side, available
//   entries on the read side, both one cycle behind the pointer state.
module gray_fifo_pointer #(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int SIDE        = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  gray_fifo_pointer_if.slave    bus
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] ptr_bin_q, ptr_bin_d;
  logic [PW-1:0] ptr_gray_q, ptr_gray_d;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] sync_d [SYNC_STAGES];
  logic [PW-1:0] peer_sync;
  logic          full;
  logic          empty;
  logic          adv_rdy;

  assign peer_sync = sync_q[SYNC_STAGES-1];

  // Write side is full when the pointers differ only in the wrap bit; in
  // Gray code that is the top two bits inverted, the rest equal.
  assign full    = (ptr_gray_q == {~peer_sync[ADDR_WIDTH:ADDR_WIDTH-1],
                                   peer_sync[ADDR_WIDTH-2:0]});
  assign empty   = (ptr_gray_q == peer_sync);
  assign adv_rdy = (SIDE == 0) ? !full : !empty;

  always_comb begin
    ptr_bin_d = ptr_bin_q;
    if (bus.clear__ENA) begin
      ptr_bin_d = '0;
    end else if (bus.advance__ENA && adv_rdy) begin
      ptr_bin_d = ptr_bin_q + 1'b1;
    end
    // Gray is registered alongside binary so the exported pointer has no
    // combinational path from any input.
    ptr_gray_d = ptr_bin_d ^ (ptr_bin_d >> 1);
  end

  always_comb begin
    sync_d[0] = bus.peerGray;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_bin_q  <= '0;
      ptr_gray_q <= '0;
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      ptr_bin_q  <= ptr_bin_d;
      ptr_gray_q <= ptr_gray_d;
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
    end
  end

  assign bus.advance__RDY = adv_rdy;
  assign bus.ptrGray      = ptr_gray_q;
  assign bus.ptrBin       = ptr_bin_q;
  assign bus.addr         = ptr_bin_q[ADDR_WIDTH-1:0];

`ifdef GRAY_PTR_LEVEL_EN
  logic [PW-1:0] peer_bin;
  logic [PW-1:0] level_d, level_q;

  // Gray-to-binary: bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    peer_bin = '0;
    for (int i = 0; i < PW; i++) begin
      peer_bin[i] = ^(peer_sync >> i);
    end
    level_d = (SIDE == 0) ? (ptr_bin_q - peer_bin) : (peer_bin - ptr_bin_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign bus.level = level_q;
`endif

endmodule

// File: tb/tb_gray_fifo_pointer.sv
module tb_gray_fifo_pointer;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int MASK  = (1 << (AW + 1)) - 1;

  typedef struct {
    int   cyc;
    int   side;
    int   bin;
    int   gray;
    bit   rdy;
    int   lvl;
    bit   adv;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  gray_fifo_pointer_if #(.ADDR_WIDTH(AW)) bus_w ();
  gray_fifo_pointer_if #(.ADDR_WIDTH(AW)) bus_r ();

  gray_fifo_pointer #(.ADDR_WIDTH(AW), .SYNC_STAGES(2), .SIDE(0)) dut_w (
    .CLK(CLK), .RST(RST), .bus(bus_w));
  gray_fifo_pointer #(.ADDR_WIDTH(AW), .SYNC_STAGES(2), .SIDE(1)) dut_r (
    .CLK(CLK), .RST(RST), .bus(bus_r));

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model: pointers as plain counts, the synchroniser as a
  // two-deep history of the peer count, status from count differences.
  int m_ptr  [2];
  int m_hist [2][2];
  int peer_bin [2];
  int prev_gray [2];

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic int to_gray(int b);
    return b ^ (b >> 1);
  endfunction

  function automatic bit model_rdy(int s, int p, int pe);
    if (s == 0) return ((p - pe) & MASK) != DEPTH;
    return p != pe;
  endfunction

  task automatic chk(string nm, int s, logic [7:0] act, logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s side%0d cyc%0d: got %0d required %0d", nm, s, cyc, act, req);
    end
  endtask

  task automatic step(bit r, bit e0, bit e1, bit c0, bit c1);
    exp_t e;
    int   last, lvl;
    bit   ena, clr, adv;
    RST = r;
    bus_w.advance__ENA = e0;
    bus_w.clear__ENA   = c0;
    bus_w.peerGray     = 3'(to_gray(peer_bin[0]));
    bus_r.advance__ENA = e1;
    bus_r.clear__ENA   = c1;
    bus_r.peerGray     = 3'(to_gray(peer_bin[1]));
    for (int s = 0; s < 2; s++) begin
      ena  = (s == 0) ? e0 : e1;
      clr  = (s == 0) ? c0 : c1;
      last = m_hist[s][1];
      adv  = 1'b0;
      if (r) lvl = 0;
      else   lvl = (s == 0) ? ((m_ptr[s] - last) & MASK) : ((last - m_ptr[s]) & MASK);
      if (r) begin
        m_ptr[s] = 0;
        m_hist[s][0] = 0;
        m_hist[s][1] = 0;
      end else begin
        if (clr) m_ptr[s] = 0;
        else if (ena && model_rdy(s, m_ptr[s], last)) begin
          m_ptr[s] = (m_ptr[s] + 1) & MASK;
          adv = 1'b1;
        end
        m_hist[s][1] = m_hist[s][0];
        m_hist[s][0] = peer_bin[s];
      end
      e.cyc  = cyc + 1;
      e.side = s;
      e.bin  = m_ptr[s];
      e.gray = to_gray(m_ptr[s]);
      e.rdy  = model_rdy(s, m_ptr[s], m_hist[s][1]);
      e.lvl  = lvl;
      e.adv  = adv;
      sb.push_back(e);
    end
    @(posedge CLK);
    #1;
  endtask

  // Monitor: whenever the DUT has produced the state an entry refers to,
  // pop it and compare against what the pointers present.
  always @(negedge CLK) begin
    exp_t e;
    logic [2:0] bin, gray;
    logic [1:0] addr;
    logic       rdy;
    logic [2:0] lvl;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.side == 0) begin
        bin = bus_w.ptrBin; gray = bus_w.ptrGray; addr = bus_w.addr; rdy = bus_w.advance__RDY;
`ifdef GRAY_PTR_LEVEL_EN
        lvl = bus_w.level;
`else
        lvl = 3'(e.lvl);
`endif
      end else begin
        bin = bus_r.ptrBin; gray = bus_r.ptrGray; addr = bus_r.addr; rdy = bus_r.advance__RDY;
`ifdef GRAY_PTR_LEVEL_EN
        lvl = bus_r.level;
`else
        lvl = 3'(e.lvl);
`endif
      end
      chk("ptrBin",  e.side, 8'(bin),  8'(e.bin));
      chk("ptrGray", e.side, 8'(gray), 8'(e.gray));
      chk("addr",    e.side, 8'(addr), 8'(e.bin & (DEPTH - 1)));
      chk("rdy",     e.side, 8'(rdy),  8'(e.rdy));
`ifdef GRAY_PTR_LEVEL_EN
      chk("level",   e.side, 8'(lvl),  8'(e.lvl));
`endif
      if (e.adv) chk("gray_onebit", e.side, 8'($countones(3'(prev_gray[e.side]) ^ gray)), 8'd1);
      prev_gray[e.side] = int'(gray);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_w.advance__ENA = 1'b0; bus_w.clear__ENA = 1'b0; bus_w.peerGray = '0;
    bus_r.advance__ENA = 1'b0; bus_r.clear__ENA = 1'b0; bus_r.peerGray = '0;
    for (int s = 0; s < 2; s++) begin
      m_ptr[s] = 0; m_hist[s][0] = 0; m_hist[s][1] = 0; peer_bin[s] = 0; prev_gray[s] = 0;
    end
    @(posedge CLK);
    #1;

    // 1: write side fills to full, 5th advance ignored; read side stays empty
    step(1, 0, 0, 0, 0);
    repeat (5) step(0, 1, 1, 0, 0);

    // 2: peer read pointer moves to 1, one more write accepted, full again
    peer_bin[0] = 1;
    repeat (3) step(0, 0, 0, 0, 0);
    repeat (2) step(0, 1, 0, 0, 0);

    // 3: read side, peer write pointer = 3, three reads then ENA held
    peer_bin[1] = 3;
    repeat (2) step(0, 0, 0, 0, 0);
    repeat (6) step(0, 0, 1, 0, 0);

    // 4: wrap on write side with peer tracking the pointer
    peer_bin[0] = 0; peer_bin[1] = 0;
    step(1, 0, 0, 0, 0);
    repeat (12) begin
      peer_bin[0] = m_ptr[0];
      step(0, 1, 0, 0, 0);
    end

    // 5: clear priority over advance, then reset with ENA high
    peer_bin[0] = 3;
    step(1, 0, 0, 0, 0);
    repeat (5) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 1);
    repeat (2) step(0, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    peer_bin[0] = 0; peer_bin[1] = 0;
    repeat (2) step(0, 0, 0, 0, 0);

    // 6: level tracking
    step(1, 0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0);
    peer_bin[0] = 2;
    repeat (4) step(0, 0, 0, 0, 0);

    // random phase
    repeat (3000) begin
      for (int s = 0; s < 2; s++)
        if ($urandom_range(0, 2) == 0) peer_bin[s] = (peer_bin[s] + 1) & MASK;
      step($urandom_range(0, 199) == 0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0);
    end

    repeat (3) @(negedge CLK);
    chk("scoreboard_drained", 0, 8'(sb.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
